// File: rtl/cache_flush_ctrl.sv
// Full-cache flush/invalidate walker: visits every set/way, writes back dirty
// lines through the bus handshake and clears dirty (optionally valid) bits.
module cache_flush_ctrl #(
  parameter int unsigned NUMWAYS  = 4,
  parameter int unsigned NUMLINES = 128,
  parameter int unsigned SETLEN   = 7
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               FlushStart,
  input  logic               FlushInvalidate,
  input  logic               PortGrant,
  input  logic               WayValid,
  input  logic               WayDirty,
  input  logic               WbAck,
  output logic               PortReq,
  output logic [SETLEN-1:0]  FlushAdr,
  output logic [NUMWAYS-1:0] FlushWay,
  output logic               WbReq,
  output logic               ClearDirty,
  output logic               ClearValid,
  output logic               FlushBusy,
  output logic               FlushDone
);

  localparam int unsigned WAYLEN = $clog2(NUMWAYS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CHECK = 3'd2,
    WB    = 3'd3,
    CLEAR = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t             state;
  logic [SETLEN-1:0]  setCnt;
  logic [WAYLEN-1:0]  wayCnt;
  logic [NUMWAYS-1:0] wayOneHot;
  logic               mode;

  logic lastEntry;
  logic checkDone;
  logic entryDone;

  // End of walk is detected on the counters themselves, no terminal-count bit.
  assign lastEntry = (setCnt == SETLEN'(NUMLINES - 1)) && (wayCnt == WAYLEN'(NUMWAYS - 1));
  assign checkDone = (state == CHECK) && !(WayValid && (WayDirty || mode));
  assign entryDone = checkDone || ((state == CLEAR) && PortGrant);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      setCnt    <= '0;
      wayCnt    <= '0;
      wayOneHot <= NUMWAYS'(1);
      mode      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          setCnt    <= '0;
          wayCnt    <= '0;
          wayOneHot <= NUMWAYS'(1);
          if (FlushStart) begin
            mode  <= FlushInvalidate;
            state <= READ;
          end
        end
        READ:  if (PortGrant) state <= CHECK;
        CHECK: begin
          if (WayValid && WayDirty)  state <= WB;
          else if (WayValid && mode) state <= CLEAR;
        end
        WB:    if (WbAck) state <= CLEAR;
        CLEAR: state <= CLEAR;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase

      // Advance: way is the inner loop, set the outer loop.
      if (entryDone) begin
        if (lastEntry) begin
          state <= DONE;
        end else begin
          wayCnt    <= wayCnt + WAYLEN'(1);
          wayOneHot <= {wayOneHot[NUMWAYS-2:0], wayOneHot[NUMWAYS-1]};
          if (wayCnt == WAYLEN'(NUMWAYS - 1)) setCnt <= setCnt + SETLEN'(1);
          state <= READ;
        end
      end
    end
  end

  // Status outputs decode straight from flops; clear strobes qualify on the live grant.
  assign PortReq    = (state == READ) || (state == CLEAR);
  assign FlushAdr   = setCnt;
  assign FlushWay   = wayOneHot;
  assign WbReq      = (state == WB);
  assign ClearDirty = (state == CLEAR) && PortGrant;
  assign ClearValid = (state == CLEAR) && PortGrant && mode;
  assign FlushBusy  = (state == READ) || (state == CHECK) || (state == WB) || (state == CLEAR);
  assign FlushDone  = (state == DONE);

endmodule

// File: doc/cache_flush_ctrl.md
Name: cache_flush_ctrl

Overview:
- Sequences a full-cache flush/invalidate walk over every set and way of a set-associative cache.
- For each entry it reads the tag/valid/dirty arrays and writes back dirty lines through the bus handshake. It then clears dirty (and optionally valid) bits.
- Sits beside the cache datapath and replacement logic. It requests the shared array port from the cache's port arbiter and drives FlushAdr/FlushWay into the address-select mux.

Parameters:
NUMWAYS, 4, associativity (power of 2, >=2)
NUMLINES, 128, number of sets (power of 2, >=2)
SETLEN, 7, set index width, equals log2(NUMLINES)

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
FlushStart  input  1  one-cycle request to begin a walk; ignored unless in IDLE
FlushInvalidate  input  1  sampled with FlushStart; 1 also clears valid bits
PortGrant  input  1  array port granted this cycle
WayValid  input  1  valid bit of FlushAdr/FlushWay, returned the cycle after READ
WayDirty  input  1  dirty bit of same entry, same timing as WayValid
WbAck  input  1  writeback accepted; ignored unless WbReq high
PortReq  output  1  requesting array port
FlushAdr  output  SETLEN  current set index
FlushWay  output  NUMWAYS  current way, one-hot
WbReq  output  1  writeback request for current entry
ClearDirty  output  1  clear dirty bit of current entry
ClearValid  output  1  clear valid bit of current entry
FlushBusy  output  1  walk in progress
FlushDone  output  1  one-cycle completion pulse

Behaviour:
- Reset state: IDLE, set counter 0, way counter 0, mode bit 0. Every output is 0, except FlushWay = one-hot way 0 (value 1).
- Reset is asynchronous and can occur mid-walk. The block returns to IDLE immediately, produces no FlushDone, and deasserts WbReq the same cycle.
- Walk order: way is the inner loop (0..NUMWAYS-1), set is the outer loop (0..NUMLINES-1). FlushAdr is the set counter. FlushWay is the decoded way counter.
- FSM states: IDLE, READ, CHECK, WB, CLEAR, DONE.
- IDLE:
  - FlushStart=1 -> READ.
  - Mode bit latches FlushInvalidate.
  - Both counters are zeroed.
- READ:
  - PortReq=1.
  - PortGrant=1 -> CHECK. Otherwise hold in READ; counters do not change.
- CHECK:
  - WayValid and WayDirty are sampled.
  - valid & dirty -> WB.
  - valid & ~dirty & mode=1 -> CLEAR.
  - Otherwise the entry is complete (advance rule below).
- WB:
  - WbReq=1. FlushAdr and FlushWay are held stable.
  - WbAck=1 -> CLEAR. There is no timeout.
- CLEAR:
  - PortReq=1.
  - While PortGrant=1: ClearDirty=1 and ClearValid=mode.
  - When PortGrant=1 the entry is complete. Otherwise hold in CLEAR with both clear strobes at 0.
- Entry complete (advance rule):
  - If set=NUMLINES-1 and way=NUMWAYS-1 -> DONE.
  - Otherwise increment way. When way wraps from NUMWAYS-1 to 0, increment set. Then -> READ.
- DONE: FlushDone=1 for exactly one cycle, FlushBusy=0, then -> IDLE.
- FlushBusy=1 in READ, CHECK, WB and CLEAR only.
- FlushStart while busy, or in DONE, is ignored and is not queued.
- Latency with PortGrant tied high:
  - A clean entry costs 2 cycles.
  - A clean entry in invalidate mode that is valid costs 3 cycles.
  - A dirty entry costs 3 cycles plus the WB wait (WB cycles up to and including the WbAck cycle).
- Counter widths: set counter is exactly SETLEN bits, way counter is log2(NUMWAYS) bits. No extra terminal-count bit is used; the end of the walk is detected by comparing both counters against their maximum values.
- ClearDirty and ClearValid never assert in the same cycle as WbReq.

Test Plan:
1. NUMLINES=4, NUMWAYS=2, all entries invalid, PortGrant=1, FlushStart pulse at cycle 0 -> FlushBusy high cycles 1-16, FlushDone pulse at cycle 17. FlushAdr/FlushWay step (0,01),(0,10),(1,01)...(3,10). No WbReq, no clears.
2. Same geometry, only set 2 way 1 valid+dirty, mode 0, WbAck returned 3 cycles after WbReq rises -> WbReq held with FlushAdr=2, FlushWay=10. Then one ClearDirty pulse with ClearValid=0. Walk completes with the 4-cycle WB wait added to total latency.
3. Mode 1, all entries valid+clean -> exactly 8 ClearValid pulses, each with ClearDirty=1; no WbReq; FlushDone after 24 busy cycles.
4. PortGrant deasserted for 5 cycles during READ of set 1 way 0, and for 2 cycles during a CLEAR -> PortReq stays high, counters and outputs frozen, no clear strobe until grant. Walk otherwise correct.
5. reset_n driven low while WbReq=1 at set 3 -> WbReq, FlushBusy drop asynchronously; FlushDone never asserts. A new FlushStart after release restarts at set 0 way 0.
6. FlushStart pulsed during busy and in the DONE cycle; WbAck pulsed while WbReq=0 -> no effect. Exactly one FlushDone per accepted start.
